// File: rtl/combined_tilelink_pkg.sv
// combined_tilelink_pkg
//   Shared definitions for the memory-stage TileLink-UL bridge:
//   TileLink opcodes, bit positions of the load (22-bit) and store (54-bit)
//   request words, and the bridge FSM state type.
package combined_tilelink_pkg;

  // A-channel opcodes
  localparam logic [2:0] TL_GET      = 3'd4;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  // D-channel opcodes
  localparam logic [2:0] TL_ACK      = 3'd0;
  localparam logic [2:0] TL_ACK_DATA = 3'd1;

  // Load request word: [21:15] opcode, [14:10] rd, [9:0] address
  localparam int unsigned LD_W        = 22;
  localparam int unsigned LD_OP_LSB   = 15;
  localparam int unsigned LD_RD_LSB   = 10;
  localparam int unsigned LD_ADDR_LSB = 0;

  // Store request word: [53:47] opcode, [46:42] zero, [41:32] address, [31:0] data
  localparam int unsigned ST_W        = 54;
  localparam int unsigned ST_OP_LSB   = 47;
  localparam int unsigned ST_ADDR_LSB = 32;
  localparam int unsigned ST_DATA_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_D
  } state_t;

endpackage

// File: rtl/combined_tilelink_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered occupancy count.
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     i_push, i_data : write request and data
//     i_pop          : read request (ignored when empty)
//     o_head         : entry at the read pointer (valid when !o_empty)
//     o_full/o_empty : occupancy flags from the registered count
//     o_drop         : this cycle's push was refused (full and not popping)
module sync_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;
  assign o_head    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/combined_tilelink.sv
// combined_tilelink
//   Memory-stage bridge to a TileLink-UL data port. Load and store requests
//   are queued in separate FIFOs; stores have fixed priority. One A-channel
//   transaction is outstanding at a time; Get responses are returned as a
//   one-cycle resp_valid pulse tagged with the destination register.
//   Ports:
//     load_fifo_write_* / store_fifo_write_* : request pushes
//     load_fifo_full / store_fifo_full / overflow : queue status (overflow sticky)
//     a_* : TileLink A channel (master side)
//     d_* : TileLink D channel (master side)
//     resp_valid / resp_rd / resp_data : returned load data
//   Optional: define COMBINED_TILELINK_STATS_EN to add load_count/store_count
//   (completed Get / Put responses, 16-bit wrapping).
module combined_tilelink
  import combined_tilelink_pkg::*;
#(
  parameter int unsigned LOAD_DEPTH  = 4,
  parameter int unsigned STORE_DEPTH = 4,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_fifo_write_signal,
  input  logic [21:0]       load_fifo_write_data,
  input  logic              store_fifo_write_signal,
  input  logic [53:0]       store_fifo_write_data,
  output logic              load_fifo_full,
  output logic              store_fifo_full,
  output logic              overflow,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [4:0]        a_source,
  output logic [ADDR_W-1:0] a_address,
  output logic [31:0]       a_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_opcode,
  input  logic [4:0]        d_source,
  input  logic [31:0]       d_data,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data
`ifdef COMBINED_TILELINK_STATS_EN
  ,
  output logic [15:0]       load_count,
  output logic [15:0]       store_count
`endif
);

  state_t              r_state, w_next;
  logic [LD_W-1:0]     w_ld_head;
  logic [ST_W-1:0]     w_st_head;
  logic                w_ld_empty, w_st_empty, w_ld_drop, w_st_drop;
  logic                w_latch_ld, w_latch_st, w_pop_ld, w_pop_st, w_done;
  logic                r_is_store;
  logic [2:0]          r_a_opcode;
  logic [4:0]          r_a_source;
  logic [ADDR_W-1:0]   r_a_address;
  logic [31:0]         r_a_data;
  logic                r_resp_valid;
  logic [4:0]          r_resp_rd;
  logic [31:0]         r_resp_data;
  logic                r_overflow;
  logic                w_unused;

  // Opcode fields are carried through the FIFOs but never interpreted.
  assign w_unused = ^{w_ld_head[LD_W-1:LD_OP_LSB], w_st_head[ST_W-1:ST_OP_LSB],
                      d_opcode};

  sync_fifo #(.WIDTH(LD_W), .DEPTH(LOAD_DEPTH)) u_load_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (load_fifo_write_signal),
    .i_data  (load_fifo_write_data),
    .i_pop   (w_pop_ld),
    .o_head  (w_ld_head),
    .o_full  (load_fifo_full),
    .o_empty (w_ld_empty),
    .o_drop  (w_ld_drop)
  );

  sync_fifo #(.WIDTH(ST_W), .DEPTH(STORE_DEPTH)) u_store_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (store_fifo_write_signal),
    .i_data  (store_fifo_write_data),
    .i_pop   (w_pop_st),
    .o_head  (w_st_head),
    .o_full  (store_fifo_full),
    .o_empty (w_st_empty),
    .o_drop  (w_st_drop)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_latch_ld = 1'b0;
    w_latch_st = 1'b0;
    w_pop_ld   = 1'b0;
    w_pop_st   = 1'b0;
    w_done     = 1'b0;
    a_valid    = 1'b0;
    d_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_st_empty) begin
          w_latch_st = 1'b1;
          w_next     = S_REQ;
        end else if (!w_ld_empty) begin
          w_latch_ld = 1'b1;
          w_next     = S_REQ;
        end
      end
      S_REQ: begin
        a_valid = 1'b1;
        if (a_ready) begin
          // The head stays in its FIFO until the slave accepts the beat.
          w_pop_st = r_is_store;
          w_pop_ld = ~r_is_store;
          w_next   = S_WAIT_D;
        end
      end
      S_WAIT_D: begin
        d_ready = 1'b1;
        if (d_valid) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_store   <= 1'b0;
      r_a_opcode   <= '0;
      r_a_source   <= '0;
      r_a_address  <= '0;
      r_a_data     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rd    <= '0;
      r_resp_data  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_latch_st) begin
        r_is_store  <= 1'b1;
        r_a_opcode  <= TL_PUT_FULL;
        r_a_source  <= '0;
        r_a_address <= w_st_head[ST_ADDR_LSB +: ADDR_W];
        r_a_data    <= w_st_head[ST_DATA_LSB +: 32];
      end else if (w_latch_ld) begin
        r_is_store  <= 1'b0;
        r_a_opcode  <= TL_GET;
        r_a_source  <= w_ld_head[LD_RD_LSB +: 5];
        r_a_address <= w_ld_head[LD_ADDR_LSB +: ADDR_W];
        r_a_data    <= '0;
      end
      r_resp_valid <= w_done & ~r_is_store;
      if (w_done && !r_is_store) begin
        r_resp_rd   <= d_source;
        r_resp_data <= d_data;
      end
      r_overflow <= r_overflow | w_ld_drop | w_st_drop;
    end
  end

  assign a_opcode   = r_a_opcode;
  assign a_source   = r_a_source;
  assign a_address  = r_a_address;
  assign a_data     = r_a_data;
  assign resp_valid = r_resp_valid;
  assign resp_rd    = r_resp_rd;
  assign resp_data  = r_resp_data;
  assign overflow   = r_overflow;

`ifdef COMBINED_TILELINK_STATS_EN
  logic [15:0] r_load_count, r_store_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_count  <= '0;
      r_store_count <= '0;
    end else if (w_done) begin
      if (r_is_store) r_store_count <= r_store_count + 16'd1;
      else            r_load_count  <= r_load_count + 16'd1;
    end
  end

  assign load_count  = r_load_count;
  assign store_count = r_store_count;
`endif

endmodule

// File: tb/tb_combined_tilelink.sv
module tb_combined_tilelink;

  localparam int LD = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_fifo_write_signal;
  logic [21:0] load_fifo_write_data;
  logic        store_fifo_write_signal;
  logic [53:0] store_fifo_write_data;
  logic        load_fifo_full, store_fifo_full, overflow;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode;
  logic [4:0]  a_source;
  logic [9:0]  a_address;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [4:0]  d_source;
  logic [31:0] d_data;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
`ifdef COMBINED_TILELINK_STATS_EN
  logic [15:0] load_count, store_count;
`endif

  always #5 clk = ~clk;

  combined_tilelink #(.LOAD_DEPTH(LD), .STORE_DEPTH(SD), .ADDR_W(10)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .load_fifo_write_signal  (load_fifo_write_signal),
    .load_fifo_write_data    (load_fifo_write_data),
    .store_fifo_write_signal (store_fifo_write_signal),
    .store_fifo_write_data   (store_fifo_write_data),
    .load_fifo_full          (load_fifo_full),
    .store_fifo_full         (store_fifo_full),
    .overflow                (overflow),
    .a_valid                 (a_valid),
    .a_ready                 (a_ready),
    .a_opcode                (a_opcode),
    .a_source                (a_source),
    .a_address               (a_address),
    .a_data                  (a_data),
    .d_valid                 (d_valid),
    .d_ready                 (d_ready),
    .d_opcode                (d_opcode),
    .d_source                (d_source),
    .d_data                  (d_data),
    .resp_valid              (resp_valid),
    .resp_rd                 (resp_rd),
    .resp_data               (resp_data)
`ifdef COMBINED_TILELINK_STATS_EN
    ,
    .load_count              (load_count),
    .store_count             (store_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: request queues, the transaction in flight, slave memory.
  typedef struct {
    bit          st;
    logic [2:0]  op;
    logic [4:0]  src;
    logic [9:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic [14:0] lq[$];   // {rd, addr}
  logic [41:0] sq[$];   // {addr, data}
  logic [31:0] mem [1024];
  int          phase;   // 0 nothing in flight, 1 A beat offered, 2 awaiting D beat
  txn_t        cur;
  bit          m_rv, m_ovf;
  logic [4:0]  m_rd;
  logic [31:0] m_rdata;
  int          m_lcnt, m_scnt;

  task automatic model_reset();
    lq.delete();
    sq.delete();
    phase   = 0;
    cur     = '{st: 1'b0, op: 3'd0, src: 5'd0, addr: 10'd0, data: 32'd0};
    m_rv    = 1'b0;
    m_ovf   = 1'b0;
    m_rd    = '0;
    m_rdata = '0;
    m_lcnt  = 0;
    m_scnt  = 0;
  endtask

  task automatic check_outputs();
    check("a_valid", a_valid, phase == 1);
    check("d_ready", d_ready, phase == 2);
    check("a_opcode", a_opcode, cur.op);
    check("a_source", a_source, cur.src);
    check("a_address", a_address, cur.addr);
    check("a_data", a_data, cur.data);
    check("resp_valid", resp_valid, m_rv);
    check("resp_rd", resp_rd, m_rd);
    check("resp_data", resp_data, m_rdata);
    check("load_full", load_fifo_full, lq.size() == LD);
    check("store_full", store_fifo_full, sq.size() == SD);
    check("overflow", overflow, m_ovf);
`ifdef COMBINED_TILELINK_STATS_EN
    check("load_count", load_count, m_lcnt % 65536);
    check("store_count", store_count, m_scnt % 65536);
`endif
  endtask

  // One clock: check at the negedge, drive inputs, advance the model across
  // the coming posedge, then wait to the next negedge.
  task automatic step(input bit rst, input bit pl, input logic [21:0] ld,
                      input bit ps, input logic [53:0] sd, input bit ar, input bit dv);
    int next_phase;
    bit pop_l, pop_s, nrv;
    check_outputs();
    reset                   = rst;
    load_fifo_write_signal  = pl;
    load_fifo_write_data    = ld;
    store_fifo_write_signal = ps;
    store_fifo_write_data   = sd;
    a_ready                 = ar;
    d_valid                 = dv;
    if (phase == 2) begin
      d_opcode = cur.st ? 3'd0 : 3'd1;
      d_source = cur.st ? 5'd0 : cur.src;
      d_data   = cur.st ? 32'd0 : mem[cur.addr];
    end else begin
      d_opcode = 3'($urandom);
      d_source = 5'($urandom);
      d_data   = $urandom;
    end
    if (rst) begin
      model_reset();
    end else begin
      next_phase = phase;
      pop_l = 1'b0;
      pop_s = 1'b0;
      nrv   = 1'b0;
      case (phase)
        0: begin
          if (sq.size() > 0) begin
            cur = '{st: 1'b1, op: 3'd0, src: 5'd0, addr: sq[0][41:32], data: sq[0][31:0]};
            next_phase = 1;
          end else if (lq.size() > 0) begin
            cur = '{st: 1'b0, op: 3'd4, src: lq[0][14:10], addr: lq[0][9:0], data: 32'd0};
            next_phase = 1;
          end
        end
        1: if (ar) begin
          if (cur.st) begin
            pop_s = 1'b1;
            mem[cur.addr] = cur.data;
          end else begin
            pop_l = 1'b1;
          end
          next_phase = 2;
        end
        default: if (dv) begin
          if (cur.st) begin
            m_scnt++;
          end else begin
            nrv     = 1'b1;
            m_rd    = cur.src;
            m_rdata = mem[cur.addr];
            m_lcnt++;
          end
          next_phase = 0;
        end
      endcase
      m_rv = nrv;
      if (pop_l) void'(lq.pop_front());
      if (pop_s) void'(sq.pop_front());
      if (pl) begin
        if (lq.size() < LD) lq.push_back({ld[14:10], ld[9:0]});
        else m_ovf = 1'b1;
      end
      if (ps) begin
        if (sq.size() < SD) sq.push_back({sd[41:32], sd[31:0]});
        else m_ovf = 1'b1;
      end
      phase = next_phase;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ar, input bit dv);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 22'd0, 1'b0, 54'd0, ar, dv);
  endtask

  initial begin
    logic [21:0] ld;
    logic [53:0] sd;
    int          guard;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[16] = 32'hDEADBEEF;
    reset = 1'b1;
    load_fifo_write_signal = 1'b0; load_fifo_write_data = '0;
    store_fifo_write_signal = 1'b0; store_fifo_write_data = '0;
    a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_source = '0; d_data = '0;
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b0, 22'd0, 1'b0, 54'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 22'd0, 1'b0, 54'd0, 1'b0, 1'b0);

    // Single load against an always-ready slave
    step(1'b0, 1'b1, {7'b0000011, 5'd2, 10'd16}, 1'b0, 54'd0, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);

    // Store and load pushed together: store goes first
    step(1'b0, 1'b1, {7'b0000011, 5'd7, 10'd5}, 1'b1,
         {7'b0100011, 5'd0, 10'd5, 32'h0000_00AA}, 1'b1, 1'b1);
    idle(10, 1'b1, 1'b1);

    // Five stores with A stalled: fifth is dropped
    for (int i = 0; i < 5; i++) begin
      sd = {7'b0100011, 5'd0, 10'(100 + i), 32'(32'h1000 + i)};
      step(1'b0, 1'b0, 22'd0, 1'b1, sd, 1'b0, 1'b0);
    end
    idle(2, 1'b0, 1'b0);
    idle(20, 1'b1, 1'b1);

    // A-channel backpressure
    step(1'b0, 1'b1, {7'b0000011, 5'd9, 10'd100}, 1'b0, 54'd0, 1'b0, 1'b0);
    idle(5, 1'b0, 1'b0);
    idle(6, 1'b1, 1'b1);

    // Reset while waiting for D
    step(1'b0, 1'b1, {7'b0000011, 5'd3, 10'd7}, 1'b1,
         {7'b0100011, 5'd0, 10'd8, 32'h55}, 1'b1, 1'b0);
    guard = 0;
    while (phase != 2 && guard < 20) begin
      idle(1, 1'b1, 1'b0);
      guard++;
    end
    check("reach_wait_d", phase == 2, 1'b1);
    step(1'b0, 1'b1, {7'b0000011, 5'd4, 10'd9}, 1'b1,
         {7'b0100011, 5'd0, 10'd9, 32'h66}, 1'b1, 1'b0);
    step(1'b1, 1'b0, 22'd0, 1'b0, 54'd0, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b1);

    // Three loads and two stores from reset
    step(1'b1, 1'b0, 22'd0, 1'b0, 54'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ld = {7'b0000011, 5'(10 + i), 10'(200 + i)};
      sd = {7'b0100011, 5'd0, 10'(300 + i), 32'($urandom)};
      step(1'b0, 1'b1, ld, i < 2, sd, 1'b1, 1'b1);
    end
    idle(20, 1'b1, 1'b1);
`ifdef COMBINED_TILELINK_STATS_EN
    check("stats_loads", load_count, 16'd3);
    check("stats_stores", store_count, 16'd2);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ld = 22'($urandom);
      ld[9:0] = 10'($urandom_range(0, 15));
      sd = {22'($urandom), 32'($urandom)};
      sd[41:32] = 10'($urandom_range(0, 15));
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0, ld,
           $urandom_range(0, 4) == 0, sd,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) != 0);
    end
    idle(30, 1'b1, 1'b1);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/combined_tilelink.md
Name: combined_tilelink

Overview:
- Memory-stage bridge between the five-stage pipeline and a TileLink-UL style data-memory port.
- Buffers load requests and store requests issued by the memory stage in two independent FIFOs.
- Arbitrates between the FIFOs and issues one A-channel transaction at a time.
- Returns load data, tagged with the destination register, from the D channel.

Parameters:
- LOAD_DEPTH, 4, entries in load FIFO (power of two, >=2)
- STORE_DEPTH, 4, entries in store FIFO (power of two, >=2)
- ADDR_W, 10, word address width carried in requests

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- load_fifo_write_signal  in  1  push load request
- load_fifo_write_data  in  22  [21:15] opcode, [14:10] rd, [9:0] address
- store_fifo_write_signal  in  1  push store request
- store_fifo_write_data  in  54  [53:47] opcode, [46:42] zero, [41:32] address, [31:0] data
- load_fifo_full  out  1  load FIFO full
- store_fifo_full  out  1  store FIFO full
- overflow  out  1  sticky: a push was dropped
- a_valid  out  1  A-channel request valid
- a_ready  in  1  slave accepts A beat
- a_opcode  out  3  4=Get, 0=PutFullData
- a_source  out  5  rd for Get, 0 for Put
- a_address  out  10  word address
- a_data  out  32  store data (0 for Get)
- d_valid  in  1  response valid
- d_ready  out  1  master accepts D beat
- d_opcode  in  3  1=AccessAckData, 0=AccessAck
- d_source  in  5  echoed source
- d_data  in  32  read data
- resp_valid  out  1  one-cycle pulse: load data returned
- resp_rd  out  5  destination register of returned load
- resp_data  out  32  returned load data

Behaviour:
- Reset, checked on the clock edge:
  - Both FIFOs are emptied; FSM goes to IDLE.
  - All outputs go to 0 (a_valid, d_ready, resp_valid, overflow, a_* fields, resp_*).
  - Reset mid-transaction abandons the transaction; the slave must also be reset.
- FIFOs:
  - Push when the write signal is high and the FIFO is not full.
  - A push while full is accepted only if the same cycle pops that FIFO. Otherwise the data is dropped and overflow is set (sticky until reset).
  - Full and empty are registered-count based.
  - Pointers wrap modulo depth.
  - The opcode field is stored but not interpreted.
- FSM has three states: IDLE, REQ, WAIT_D.
  - IDLE: if the store FIFO is non-empty, select store; otherwise, if the load FIFO is non-empty, select load; otherwise stay. Selecting latches the head entry into the A registers and moves to REQ the next cycle. Stores have fixed priority.
  - REQ: a_valid=1 with stable fields. On a_valid&a_ready, pop the selected FIFO in that cycle and go to WAIT_D.
  - WAIT_D: d_ready=1. On d_valid:
    - Get: register resp_valid=1, resp_rd=d_source, resp_data=d_data for exactly one cycle.
    - Put: no response pulse.
    - Then return to IDLE.
- Exactly one outstanding transaction.
- Minimum latency push→a_valid is 2 cycles, since the FIFO write is registered and IDLE selection is registered.
- A d_valid received outside WAIT_D is ignored (d_ready=0).

Optional Feature:
- Macro: COMBINED_TILELINK_STATS_EN.
- When defined:
  - Adds outputs load_count[15:0] and store_count[15:0].
  - Each counts completed D-channel responses of its type.
  - Both are cleared by reset and wrap at 65535→0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package combined_tilelink_pkg holds:
  - TL opcodes (TL_GET=3'd4, TL_PUT_FULL=3'd0, TL_ACK=3'd0, TL_ACK_DATA=3'd1).
  - Field-position constants for the 22-bit and 54-bit request words.
  - FSM state enum.
- Sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated for loads (WIDTH 22) and stores (WIDTH 54).

Test Plan:
- Load, fixed slave: reset 2 cycles, then push load {7'b0000011, rd=5'd2, addr=10'd16}; slave a_ready=1 and d_valid one cycle later with data 32'hDEADBEEF.
  - Expect a_opcode=4, a_address=16, a_source=2.
  - Expect one resp_valid pulse with resp_rd=2 and resp_data=32'hDEADBEEF.
- Priority: in one cycle push load addr 5 and store {addr 5, data 32'h0000_00AA}.
  - The first A beat is PutFullData addr 5 data 0xAA, then Get addr 5.
  - The Get returns 0xAA from the model memory.
- Full/overflow: hold a_ready=0 and push 5 stores.
  - store_fifo_full=1 after the 4th push; the 5th push sets overflow=1.
  - After releasing a_ready, exactly 4 stores issue, in order.
- Backpressure: a_ready low for 3 cycles.
  - a_valid and all a_* fields stay stable; no pop until the handshake.
- Reset mid-operation: assert reset during WAIT_D.
  - Next cycle: a_valid=0, d_ready=0, both FIFOs empty, overflow=0.
- Stats (macro defined): 3 loads and 2 stores complete → load_count=3, store_count=2.
